rsa_job_scheduler: RTL and testbench
====================================

// Module: rsa_job_scheduler
// PURPOSE
//   Shares the single RSA controller/datapath pair between NREQ requesters and one key-config port.
//   Accepts messages over valid/ready, arbitrates round-robin, and sequences the controller's input_data_type
//   pulses (1=encrypt, 2=load n, 3=load e, 0=idle). Returns each 16-bit ciphertext to its owner, with a timeout error.
//   Sits between the host-side request ports and the existing controller/datapath.
// PARAMETERS
//   NREQ     4     number of requesters (2..8)
//   TIMEOUT  4096  max cycles waiting for rsa_done per job before error
// PORTS
//   clk                  in   1          system clock, all logic on posedge
//   rst_n                in   1          reset, synchronous, active-low
//   req_valid            in   NREQ       request i has a message
//   req_data             in   13*NREQ    message i at [13*i +: 13]
//   req_ready            out  NREQ       one-hot accept pulse for granted requester
//   rsp_valid            out  NREQ       one-hot; result for requester i pending
//   rsp_ready            in   NREQ       requester i consumes result
//   rsp_data             out  16         ciphertext (0 on error)
//   rsp_err              out  1          result is a timeout
//   cfg_valid            in   1          key update request
//   cfg_is_e             in   1          1: load exponent e, 0: load modulus n
//   cfg_data             in   13         new e or n value
//   cfg_ready            out  1          one-cycle accept pulse for config
//   rsa_data             out  13         drives datapath data
//   rsa_input_data_type  out  3          drives controller input_data_type
//   rsa_done             in   1          controller done
//   rsa_output_data      in   16         datapath output_data
//   busy                 out  1          state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, rr pointer=NREQ-1, all outputs 0, timeout counter 0.
//   FSM: IDLE -> SETUP -> ISSUE -> {CFG_GAP | WAIT_LO -> WAIT_HI} -> RESP -> IDLE.
//   IDLE: cfg_valid has priority over requests. Else grant first req_valid after rr pointer (round-robin);
//     pulse req_ready[g] / cfg_ready for 1 cycle, latch data into rsa_data, latch g, go SETUP.
//   SETUP: rsa_data stable, type=0 (1 cycle setup before pulse).
//   ISSUE: type = 1 (job), 3 (cfg_is_e=1) or 2 (cfg_is_e=0) for exactly 1 cycle; then type=0.
//   CFG_GAP: 1 idle cycle, then IDLE; no response generated for config.
//   WAIT_LO: wait for rsa_done=0 (controller left previous done); WAIT_HI: wait rsa_done=1.
//     On rsa_done=1 capture rsa_output_data next cycle into rsp_data, rsp_err=0, go RESP.
//   Timeout: counter cleared at ISSUE, increments in WAIT_LO/WAIT_HI; at TIMEOUT-1 -> RESP with
//     rsp_err=1, rsp_data=0.
//   RESP: rsp_valid[g]=1, held with rsp_data/rsp_err stable until rsp_ready[g]; then rr pointer=g, IDLE.
//     rsp_ready on non-matching bits ignored. No new grant while in RESP (one job in flight).
//   rsa_data holds last value outside SETUP/ISSUE; rsa_input_data_type is 0 in every state but ISSUE.
//   Simultaneous cfg_valid and req_valid: cfg served first; requests wait, rr pointer unchanged.
//   req_valid dropped before grant: not served; no ready pulse. Grant only samples current req_valid.
//   Reset mid-job: FSM to IDLE, pending response discarded, type forced 0 same cycle as reset.
//   rr pointer wrap: after g=NREQ-1, search starts at 0.
// STRUCTURE
//   rsa_pkg: RSA_TYPE_IDLE/ENC/LOAD_N/LOAD_E (3'd0/1/2/3), DATA_W=13, OUT_W=16, state enum.
//   Sub-module rr_arbiter #(NREQ): req vector + pointer -> one-hot grant + index, combinational.
//   Timeout counter width $clog2(TIMEOUT)+1.
// TESTING
//   Bench instantiates controller + datapath + rsa_job_scheduler; clk period 20.
//   1. Default key; req0 data=2 -> rsp_valid[0], rsp_data=1752 (2^17 mod 3233), rsp_err=0.
//   2. req0..req3 all valid, data 3,4,5,6 -> served order 0,1,2,3; each rsp = d^17 mod 3233.
//   3. cfg e=17, then cfg n=323, with req1 data=2 valid -> both cfg first, then rsp_data=257.
//   4. Replace datapath with stub holding rsa_done=0, TIMEOUT=16 -> rsp_err=1, rsp_data=0, ~16 cycles.
//   5. rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, no new req_ready pulse.
//   6. rst_n=0 during WAIT_HI -> next cycle busy=0, rsp_valid=0, type=0; next job returns correct result.

Source files
------------

// File: rtl/rsa_job_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// rsa_job_scheduler_pkg
//   Shared constants and types for the RSA job scheduler:
//   - RSA controller input_data_type codes
//   - message / ciphertext widths
//   - scheduler FSM state and job-kind enums
//   - helper mapping a job kind to its controller type code
// ----------------------------------------------------------------------------
package rsa_job_scheduler_pkg;

  localparam int DATA_W = 13;
  localparam int OUT_W  = 16;
  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] RSA_TYPE_IDLE   = 3'd0;
  localparam logic [TYPE_W-1:0] RSA_TYPE_ENC    = 3'd1;
  localparam logic [TYPE_W-1:0] RSA_TYPE_LOAD_N = 3'd2;
  localparam logic [TYPE_W-1:0] RSA_TYPE_LOAD_E = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CFG_GAP = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_WAIT_HI = 3'd5,
    ST_RESP    = 3'd6
  } sched_state_e;

  typedef enum logic [1:0] {
    JOB_ENC    = 2'd0,
    JOB_LOAD_N = 2'd1,
    JOB_LOAD_E = 2'd2
  } job_kind_e;

  function automatic logic [TYPE_W-1:0] kind_to_type(input job_kind_e k);
    case (k)
      JOB_LOAD_N: return RSA_TYPE_LOAD_N;
      JOB_LOAD_E: return RSA_TYPE_LOAD_E;
      default:    return RSA_TYPE_ENC;
    endcase
  endfunction

endpackage

// File: rtl/rsa_job_scheduler_if.sv
// ----------------------------------------------------------------------------
// rsa_host_if
//   Host-side bundle: NREQ request ports (valid/ready + 13-bit message each),
//   per-requester response handshake with shared 16-bit data and error flag,
//   key-config port, and busy status.
//   master = host/requesters, slave = scheduler.
//
// rsa_ctrl_if
//   Bundle toward the existing RSA controller/datapath pair:
//   rsa_data, rsa_input_data_type, rsa_done, rsa_output_data.
//   master = scheduler, slave = controller/datapath.
// ----------------------------------------------------------------------------
interface rsa_host_if #(parameter int NREQ = 4);
  import rsa_job_scheduler_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [OUT_W-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   cfg_valid;
  logic                   cfg_is_e;
  logic [DATA_W-1:0]      cfg_data;
  logic                   cfg_ready;
  logic                   busy;

  modport master (
    output req_valid, req_data, rsp_ready, cfg_valid, cfg_is_e, cfg_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, cfg_ready, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, cfg_valid, cfg_is_e, cfg_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, cfg_ready, busy
  );
endinterface

interface rsa_ctrl_if;
  import rsa_job_scheduler_pkg::*;

  logic [DATA_W-1:0] rsa_data;
  logic [TYPE_W-1:0] rsa_input_data_type;
  logic              rsa_done;
  logic [OUT_W-1:0]  rsa_output_data;

  modport master (
    output rsa_data, rsa_input_data_type,
    input  rsa_done, rsa_output_data
  );

  modport slave (
    input  rsa_data, rsa_input_data_type,
    output rsa_done, rsa_output_data
  );
endinterface

// File: rtl/rsa_job_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Searches the request vector starting
//   at the position just after i_ptr and wrapping around, so the requester
//   at i_ptr itself has the lowest priority.
// Ports
//   i_req    in  NREQ   request vector
//   i_ptr    in  IDX_W  last-served index
//   o_grant  out NREQ   one-hot grant (all zero when no request)
//   o_idx    out IDX_W  index of the granted requester
//   o_valid  out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int  NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      // one extra bit holds ptr+k before the wrap subtraction
      w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NREQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NREQ);
      end
      if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
        o_valid                    = 1'b1;
        o_grant[w_cand[IDX_W-1:0]] = 1'b1;
        o_idx                      = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// ----------------------------------------------------------------------------
// rsa_job_scheduler
//   Shares one RSA controller/datapath pair between NREQ requesters and a
//   key-config port. Config has priority; requests are served round-robin,
//   one job in flight. Each accepted item is presented on rsa_data for one
//   setup cycle, then the controller type code is pulsed for one cycle.
//   Encrypt jobs wait for the controller's done handshake (or a timeout)
//   and the result is held for the owning requester until it is consumed.
// Ports
//   clk, rst_n  system clock, synchronous active-low reset
//   host        rsa_host_if.slave : requests, responses, config, busy
//   ctrl        rsa_ctrl_if.master: rsa_data, type, done, output_data
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | arbitrate: config first, else round-robin request
// ST_SETUP   | rsa_data stable, type 0
// ST_ISSUE   | type pulse (enc / load n / load e) for one cycle
// ST_CFG_GAP | one idle cycle after a key load, no response
// ST_WAIT_LO | wait for controller to drop done from the previous job
// ST_WAIT_HI | wait for controller done, capture result
// ST_RESP    | rsp_valid to owner until its rsp_ready
// ----------------------------------------------------------------------------
module rsa_job_scheduler
  import rsa_job_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  rsa_host_if.slave   host,
  rsa_ctrl_if.master  ctrl
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  job_kind_e          r_kind;
  logic [DATA_W-1:0]  r_rsa_data;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [OUT_W-1:0]   r_rsp_data;
  logic               r_rsp_err;

  logic [NREQ-1:0]    w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic               w_take_cfg;
  logic               w_take_req;
  logic               w_waiting;
  logic               w_timeout;
  logic               w_rsp_done;
  logic [NREQ-1:0]    w_rsp_onehot;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (host.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_take_cfg   = (r_state == ST_IDLE) && host.cfg_valid;
  assign w_take_req   = (r_state == ST_IDLE) && !host.cfg_valid && w_arb_valid;
  assign w_waiting    = (r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI);
  assign w_timeout    = w_waiting && (r_tmo_cnt == TMO_LAST);
  assign w_rsp_done   = (r_state == ST_RESP) && host.rsp_ready[r_gnt_idx];
  assign w_rsp_onehot = NREQ'(1) << r_gnt_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake and type outputs are gated by rst_n so a reset mid-job
  // silences the controller in the same cycle the reset is applied.
  always_comb begin
    w_state_nxt              = r_state;
    host.req_ready           = '0;
    host.cfg_ready           = 1'b0;
    host.rsp_valid           = '0;
    ctrl.rsa_input_data_type = RSA_TYPE_IDLE;

    unique case (r_state)
      ST_IDLE: begin
        if (w_take_cfg || w_take_req) begin
          w_state_nxt = ST_SETUP;
        end
        if (rst_n) begin
          host.cfg_ready = w_take_cfg;
          host.req_ready = w_take_req ? w_arb_grant : '0;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = (r_kind == JOB_ENC) ? ST_WAIT_LO : ST_CFG_GAP;
        if (rst_n) begin
          ctrl.rsa_input_data_type = kind_to_type(r_kind);
        end
      end
      ST_CFG_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      ST_WAIT_LO: begin
        if (w_timeout) begin
          w_state_nxt = ST_RESP;
        end else if (!ctrl.rsa_done) begin
          w_state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (ctrl.rsa_done || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_rsp_done) begin
          w_state_nxt = ST_IDLE;
        end
        if (rst_n) begin
          host.rsp_valid = w_rsp_onehot;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= IDX_W'(NREQ - 1);
      r_gnt_idx  <= '0;
      r_kind     <= JOB_ENC;
      r_rsa_data <= '0;
      r_tmo_cnt  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_take_cfg) begin
        r_kind     <= host.cfg_is_e ? JOB_LOAD_E : JOB_LOAD_N;
        r_rsa_data <= host.cfg_data;
      end else if (w_take_req) begin
        r_kind     <= JOB_ENC;
        r_gnt_idx  <= w_arb_idx;
        r_rsa_data <= host.req_data[DATA_W*w_arb_idx +: DATA_W];
      end

      if (r_state == ST_ISSUE) begin
        r_tmo_cnt <= '0;
      end else if (w_waiting && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      // a done seen on the last allowed cycle still wins over the timeout
      if ((r_state == ST_WAIT_HI) && ctrl.rsa_done) begin
        r_rsp_data <= ctrl.rsa_output_data;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end

      if (w_rsp_done) begin
        r_ptr <= r_gnt_idx;
      end
    end
  end

  assign ctrl.rsa_data = r_rsa_data;
  assign host.rsp_data = r_rsp_data;
  assign host.rsp_err  = r_rsp_err;
  assign host.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rsa_job_scheduler.sv
module tb_rsa_job_scheduler;
  import rsa_job_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  rsa_host_if #(.NREQ(NREQ)) host_a ();
  rsa_ctrl_if                ctrl_a ();
  rsa_host_if #(.NREQ(NREQ)) host_b ();
  rsa_ctrl_if                ctrl_b ();

  rsa_job_scheduler #(.NREQ(NREQ), .TIMEOUT(4096)) dut_a (
    .clk(clk), .rst_n(rst_n), .host(host_a), .ctrl(ctrl_a));
  rsa_job_scheduler #(.NREQ(NREQ), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .host(host_b), .ctrl(ctrl_b));

  // behavioural controller + datapath: key registers, enc latency LAT,
  // done held high until the next encrypt pulse
  logic [15:0] m_n, m_e, m_msg, m_out;
  logic        m_done;
  int          m_cnt;

  function automatic logic [15:0] modexp(input int unsigned b, input int unsigned e,
                                         input int unsigned n);
    longint unsigned r = 1;
    longint unsigned x = b % n;
    int unsigned     k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % n;
      x = (x * x) % n;
      k = k >> 1;
    end
    return 16'(r);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n <= 16'd3233; m_e <= 16'd17; m_msg <= '0; m_out <= '0;
      m_done <= 1'b0; m_cnt <= 0;
    end else begin
      case (ctrl_a.rsa_input_data_type)
        3'd1: begin m_done <= 1'b0; m_cnt <= LAT; m_msg <= 16'(ctrl_a.rsa_data); end
        3'd2: m_n <= 16'(ctrl_a.rsa_data);
        3'd3: m_e <= 16'(ctrl_a.rsa_data);
        default: ;
      endcase
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_out  <= modexp(32'(m_msg), 32'(m_e), 32'(m_n));
        end
      end
    end
  end

  assign ctrl_a.rsa_done        = m_done;
  assign ctrl_a.rsa_output_data = m_out;
  assign ctrl_b.rsa_done        = 1'b0;
  assign ctrl_b.rsa_output_data = 16'hBEEF;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [15:0] d, input logic e);
    exp_t x;
    x.idx = idx; x.data = d; x.err = e;
    return x;
  endfunction

  task automatic mon_a();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ((host_a.rsp_valid & host_a.rsp_ready) != 0)) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_rsp", longint'(host_a.rsp_valid), 0);
        end else begin
          e = q_a.pop_front();
          check("a_rsp_owner", longint'(host_a.rsp_valid), longint'(1) << e.idx);
          check("a_rsp_data", longint'(host_a.rsp_data), longint'(e.data));
          check("a_rsp_err", longint'(host_a.rsp_err), longint'(e.err));
        end
      end
    end
  endtask

  task automatic mon_b();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ((host_b.rsp_valid & host_b.rsp_ready) != 0)) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_rsp", longint'(host_b.rsp_valid), 0);
        end else begin
          e = q_b.pop_front();
          check("b_rsp_owner", longint'(host_b.rsp_valid), longint'(1) << e.idx);
          check("b_rsp_data", longint'(host_b.rsp_data), longint'(e.data));
          check("b_rsp_err", longint'(host_b.rsp_err), longint'(e.err));
        end
      end
    end
  endtask

  task automatic set_data_a(input int i, input logic [12:0] v);
    host_a.req_data[13*i +: 13] = v;
  endtask

  // raise the masked requests and hold each until it is accepted
  task automatic drive_reqs(input logic [NREQ-1:0] mask, input int budget);
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] acc;
    int c = 0;
    pending = mask;
    host_a.req_valid = host_a.req_valid | mask;
    while (pending != 0 && c < budget) begin
      @(negedge clk);
      c++;
      if ((host_a.req_ready & ~pending) != 0)
        check("a_spurious_ready", longint'(host_a.req_ready), longint'(pending));
      acc = host_a.req_ready & pending;
      if (acc != 0) begin
        @(posedge clk); #1;
        host_a.req_valid = host_a.req_valid & ~acc;
        pending = pending & ~acc;
      end
    end
    if (pending != 0) check("a_accept_timeout", longint'(pending), 0);
  endtask

  task automatic drive_cfg(input logic is_e, input logic [12:0] v, input int budget);
    bit got = 0;
    int c = 0;
    host_a.cfg_valid = 1'b1; host_a.cfg_is_e = is_e; host_a.cfg_data = v;
    while (!got && c < budget) begin
      @(negedge clk);
      c++;
      if (host_a.req_ready != 0)
        check("a_req_ready_during_cfg", longint'(host_a.req_ready), 0);
      if (host_a.cfg_ready) got = 1;
    end
    check("a_cfg_accept", got, 1);
    @(posedge clk); #1;
    host_a.cfg_valid = 1'b0;
  endtask

  task automatic drain_a(input int budget);
    int c = 0;
    while ((q_a.size() != 0 || host_a.busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("a_drain", q_a.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] held;
    bit stable_ok, ready_seen, got;
    int lat, c;

    host_a.req_valid = '0; host_a.req_data = '0; host_a.rsp_ready = '1;
    host_a.cfg_valid = 1'b0; host_a.cfg_is_e = 1'b0; host_a.cfg_data = '0;
    host_b.req_valid = '0; host_b.req_data = '0; host_b.rsp_ready = '1;
    host_b.cfg_valid = 1'b0; host_b.cfg_is_e = 1'b0; host_b.cfg_data = '0;

    fork
      mon_a();
      mon_b();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", host_a.busy, 0);
    check("rst_rsp_valid", longint'(host_a.rsp_valid), 0);
    check("rst_req_ready", longint'(host_a.req_ready), 0);
    check("rst_cfg_ready", host_a.cfg_ready, 0);
    check("rst_type", longint'(ctrl_a.rsa_input_data_type), 0);
    check("rst_rsa_data", longint'(ctrl_a.rsa_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // timeout on the stubbed controller (TIMEOUT=16)
    host_b.req_data[26 +: 13] = 13'd7;
    host_b.req_valid = 4'b0100;
    q_b.push_back(mk(2, 16'd0, 1'b1));
    got = 0; c = 0;
    while (!got && c < 50) begin
      @(negedge clk); c++;
      if (host_b.req_ready[2]) got = 1;
    end
    check("b_accept", got, 1);
    @(posedge clk); #1;
    host_b.req_valid = '0;
    got = 0; lat = 0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++;
      if (host_b.rsp_valid != 0) got = 1;
    end
    check("b_rsp_seen", got, 1);
    check("b_timeout_latency_in_16_20", (lat >= 16 && lat <= 20), 1);
    c = 0;
    while (q_b.size() != 0 && c < 20) begin @(negedge clk); c++; end
    check("b_drain", q_b.size(), 0);
    @(posedge clk); #1;

    // all four requesters at once, round-robin from pointer NREQ-1
    set_data_a(0, 13'd3); set_data_a(1, 13'd4); set_data_a(2, 13'd5); set_data_a(3, 13'd6);
    q_a.push_back(mk(0, 16'd1211, 1'b0));
    q_a.push_back(mk(1, 16'd1387, 1'b0));
    q_a.push_back(mk(2, 16'd3086, 1'b0));
    q_a.push_back(mk(3, 16'd824,  1'b0));
    drive_reqs(4'b1111, 400);
    drain_a(200);

    // default key, single job
    set_data_a(0, 13'd2);
    q_a.push_back(mk(0, 16'd1752, 1'b0));
    drive_reqs(4'b0001, 50);
    drain_a(100);

    // response back-pressure; other rsp_ready bits high must be ignored
    host_a.rsp_ready = 4'b1011;
    set_data_a(2, 13'd5);
    q_a.push_back(mk(2, 16'd3086, 1'b0));
    drive_reqs(4'b0100, 50);
    got = 0; c = 0;
    while (!got && c < 100) begin
      @(negedge clk); c++;
      if (host_a.rsp_valid != 0) got = 1;
    end
    check("a_hold_rsp_seen", got, 1);
    held = host_a.rsp_data;
    @(posedge clk); #1;
    set_data_a(3, 13'd6);
    host_a.req_valid[3] = 1'b1;
    q_a.push_back(mk(3, 16'd824, 1'b0));
    stable_ok = 1; ready_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (host_a.rsp_valid != 4'b0100 || host_a.rsp_data != held) stable_ok = 0;
      if (host_a.req_ready != 0) ready_seen = 1;
    end
    check("a_hold_stable", stable_ok, 1);
    check("a_hold_no_new_grant", ready_seen, 0);
    @(posedge clk); #1;
    host_a.rsp_ready = 4'b1111;
    drive_reqs(4'b1000, 100);
    drain_a(200);

    // two key loads take priority over a waiting request
    set_data_a(1, 13'd2);
    host_a.req_valid[1] = 1'b1;
    q_a.push_back(mk(1, 16'd257, 1'b0));
    drive_cfg(1'b1, 13'd17, 20);
    drive_cfg(1'b0, 13'd323, 20);
    drive_reqs(4'b0010, 50);
    drain_a(100);

    // reset while waiting for done, then a clean job on the default key
    set_data_a(0, 13'd4);
    drive_reqs(4'b0001, 50);
    got = 0; c = 0;
    while (!got && c < 20) begin
      @(negedge clk); c++;
      if (ctrl_a.rsa_input_data_type == 3'd1) got = 1;
    end
    check("a_enc_pulse_seen", got, 1);
    repeat (3) @(negedge clk);
    check("a_busy_mid_job", host_a.busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("a_type_during_reset", longint'(ctrl_a.rsa_input_data_type), 0);
    @(posedge clk);
    @(negedge clk);
    check("a_post_rst_busy", host_a.busy, 0);
    check("a_post_rst_rsp_valid", longint'(host_a.rsp_valid), 0);
    check("a_post_rst_type", longint'(ctrl_a.rsa_input_data_type), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_data_a(0, 13'd2);
    q_a.push_back(mk(0, 16'd1752, 1'b0));
    drive_reqs(4'b0001, 50);
    drain_a(100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
